// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiplier controller that borrows the LEGv8 ALU.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
// Contents: LEGv8 ALU function-select encodings, status bit indices, FSM state type.
package alu_mul_sequencer_pkg;

  // LEGv8 ALU function select: FS[4:2] = operation, FS[1] = invert A, FS[0] = invert B
  localparam logic [4:0] FS_AND      = 5'b00000;
  localparam logic [4:0] FS_OR       = 5'b00100;
  localparam logic [4:0] FS_ADD      = 5'b01000;
  localparam logic [4:0] FS_NEGB_ADD = 5'b01001;
  localparam logic [4:0] FS_XOR      = 5'b01100;
  localparam logic [4:0] FS_LSL      = 5'b10000;
  localparam logic [4:0] FS_LSR      = 5'b10100;

  // Bit positions inside the ALU {V,C,N,Z} status vector
  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_C = 2;
  localparam int ST_V = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_CALC   = 3'd3,
    ST_NEG_LO = 3'd4,
    ST_NEG_HI = 3'd5,
    ST_DONE   = 3'd6
  } mul_state_t;

  // States in which the datapath must route the ALU inputs to this block
  function automatic logic owns_alu(input mul_state_t s);
    return (s == ST_NEG_A) || (s == ST_NEG_B) || (s == ST_CALC) ||
           (s == ST_NEG_LO) || (s == ST_NEG_HI);
  endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// WIDTHxWIDTH->2*WIDTH shift-add multiplier sequencer driving the shared LEGv8 ALU, with signed fix-up.
// Latency: WIDTH+1 cycles unsigned, +1 per negated operand, +2 when the product must be negated.
// Backpressure: none; start is only sampled in IDLE, requests while busy or in DONE are dropped.
// Ports: clock_i/reset_i (sync, active-high); start_i/signed_op_i/op_a_i/op_b_i request;
//        busy_o/done_o/product_hi_o/product_lo_o result; alu_sel_o/alu_a_o/alu_b_o/alu_fs_o/alu_c0_o
//        drive the ALU; alu_f_i/alu_status_i are its combinational result and {V,C,N,Z} flags.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_hi_o,
  output logic [WIDTH-1:0] product_lo_o,
  output logic             alu_sel_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [4:0]       alu_fs_o,
  output logic             alu_c0_o,
  input  logic [WIDTH-1:0] alu_f_i,
  input  logic [3:0]       alu_status_i
);

  localparam int CW = $clog2(WIDTH);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;   // multiplier, shifted out as the low product shifts in
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_b_q, neg_b_d;
  logic             carry_q, carry_d;
  logic             busy_q, done_q, alu_sel_q;

  logic alu_c;
  assign alu_c = alu_status_i[ST_C];

  // Only the carry flag matters; the rest is deliberately dropped.
  logic unused_status;
  assign unused_status = alu_status_i[ST_V] ^ alu_status_i[ST_N] ^ alu_status_i[ST_Z];

  // ALU drive is a pure decode of the current state and datapath registers.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_fs_o = '0;
    alu_c0_o = 1'b0;
    case (state_q)
      ST_NEG_A:  begin alu_b_o = mcand_q; alu_fs_o = FS_NEGB_ADD; alu_c0_o = 1'b1; end
      ST_NEG_B:  begin alu_b_o = lo_q;    alu_fs_o = FS_NEGB_ADD; alu_c0_o = 1'b1; end
      ST_CALC:   begin alu_a_o = hi_q; alu_b_o = mcand_q; alu_fs_o = FS_ADD; end
      ST_NEG_LO: begin alu_b_o = lo_q;    alu_fs_o = FS_NEGB_ADD; alu_c0_o = 1'b1; end
      // Upper half of the 2W-bit negate: ~hi plus the carry out of the low half
      ST_NEG_HI: begin alu_b_o = hi_q;    alu_fs_o = FS_NEGB_ADD; alu_c0_o = carry_q; end
      default:   ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_b_d   = neg_b_q;
    carry_d   = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mcand_d   = op_a_i;
          lo_d      = op_b_i;
          hi_d      = '0;
          cnt_d     = CW'(WIDTH - 1);
          neg_res_d = signed_op_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
          neg_b_d   = signed_op_i & op_b_i[WIDTH-1];
          if (signed_op_i & op_a_i[WIDTH-1])      state_d = ST_NEG_A;
          else if (signed_op_i & op_b_i[WIDTH-1]) state_d = ST_NEG_B;
          else                                    state_d = ST_CALC;
        end
      end
      ST_NEG_A: begin
        mcand_d = alu_f_i;
        state_d = neg_b_q ? ST_NEG_B : ST_CALC;
      end
      ST_NEG_B: begin
        lo_d    = alu_f_i;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        // Shift the {carry, sum-or-hi, lo} window right by one each iteration
        if (lo_q[0]) begin
          hi_d = {alu_c, alu_f_i[WIDTH-1:1]};
          lo_d = {alu_f_i[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = neg_res_q ? ST_NEG_LO : ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_NEG_LO: begin
        lo_d    = alu_f_i;
        carry_d = alu_c;
        state_d = ST_NEG_HI;
      end
      ST_NEG_HI: begin
        hi_d    = alu_f_i;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_b_q   <= 1'b0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_b_q   <= neg_b_d;
      carry_q   <= carry_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      alu_sel_q <= owns_alu(state_d);
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign alu_sel_o    = alu_sel_q;
  // hi/lo only move while busy, so they hold the last product until the next accept
  assign product_hi_o = hi_q;
  assign product_lo_o = lo_q;

endmodule
